// File: rtl/ham_7_4_stream_enc.sv
// Streaming Hamming(7,4) encoder: one byte in, two 7-bit codewords out (layout [7:1]),
// with a one-shot single-bit error-injection hook for exercising the downstream decoder.
module ham_7_4_stream_enc #(
  parameter int CNT_W    = 16,
  parameter int LO_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:1]       out_code,
  output logic             out_injected,
  input  logic             inj_valid,
  input  logic [2:0]       inj_pos,
  output logic             inj_armed,
  output logic [CNT_W-1:0] cw_count
);

  typedef enum logic [1:0] {IDLE, FIRST, SECOND} state_t;

  state_t     state, state_next;
  logic [3:0] second_q;
  logic [2:0] pos_q;
  logic       take_byte, take_second, load;
  logic [3:0] first_nib, second_nib, load_nib;
  logic [7:0] shifted;
  logic [7:1] flip_mask, load_code;

  function automatic logic [7:1] encode(input logic [3:0] d);
    logic [7:1] c;
    c[1] = d[0];
    c[2] = d[1];
    c[3] = d[2];
    c[5] = d[3];
    c[7] = d[3] ^ d[2] ^ d[0];
    c[6] = d[3] ^ d[1] ^ d[0];
    c[4] = d[2] ^ d[1] ^ d[0];
    return c;
  endfunction

  assign first_nib  = (LO_FIRST != 0) ? in_data[3:0] : in_data[7:4];
  assign second_nib = (LO_FIRST != 0) ? in_data[7:4] : in_data[3:0];

  always_comb begin
    state_next  = state;
    in_ready    = 1'b0;
    take_byte   = 1'b0;
    take_second = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          take_byte  = 1'b1;
          state_next = FIRST;
        end
      end
      FIRST: begin
        if (out_ready) begin
          take_second = 1'b1;
          state_next  = SECOND;
        end
      end
      SECOND: begin
        in_ready = out_ready;
        if (out_ready) begin
          if (in_valid) begin
            take_byte  = 1'b1;
            state_next = FIRST;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A pending injection flips its stored bit in whichever codeword is loaded next
  assign load      = take_byte | take_second;
  assign load_nib  = take_byte ? first_nib : second_q;
  assign shifted   = 8'd1 << pos_q;
  assign flip_mask = inj_armed ? shifted[7:1] : 7'd0;
  assign load_code = encode(load_nib) ^ flip_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_q     <= '0;
      pos_q        <= '0;
      out_valid    <= 1'b0;
      out_code     <= '0;
      out_injected <= 1'b0;
      inj_armed    <= 1'b0;
      cw_count     <= '0;
    end else begin
      if (take_byte) second_q <= second_nib;
      if (load) begin
        out_code     <= load_code;
        out_injected <= inj_armed;
      end
      if (take_byte)                       out_valid <= 1'b1;
      else if (state == SECOND && out_ready) out_valid <= 1'b0;
      if (out_valid && out_ready) cw_count <= cw_count + 1'b1;
      // A request landing on a load re-arms for the following load
      if (inj_valid && inj_pos != 3'd0) begin
        inj_armed <= 1'b1;
        pos_q     <= inj_pos;
      end else if (load) begin
        inj_armed <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ham_7_4_stream_enc.sv
// Self-checking bench for ham_7_4_stream_enc: table vectors, hand corner cases and a
// randomized scoreboard phase; a second instance covers CNT_W=2 and high-nibble-first.
module tb_ham_7_4_stream_enc;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, out_ready, inj_valid;
  logic [7:0] in_data;
  logic [2:0] inj_pos;
  logic       in_ready, out_valid, out_injected, inj_armed;
  logic [7:1] out_code;
  logic [15:0] cw_count;
  logic       in_ready2, out_valid2, out_injected2, inj_armed2;
  logic [7:1] out_code2;
  logic [1:0] cw_count2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ham_7_4_stream_enc #(.CNT_W(16), .LO_FIRST(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .out_injected(out_injected), .inj_valid(inj_valid), .inj_pos(inj_pos),
    .inj_armed(inj_armed), .cw_count(cw_count)
  );

  ham_7_4_stream_enc #(.CNT_W(2), .LO_FIRST(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_code(out_code2),
    .out_injected(out_injected2), .inj_valid(inj_valid), .inj_pos(inj_pos),
    .inj_armed(inj_armed2), .cw_count(cw_count2)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [7:0] d, input logic ordy);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
  endtask

  function automatic int bitk(input int v, input int k);
    return (v >> (k - 1)) & 1;
  endfunction

  // Reference: search the 128 words for the one whose data bits match and whose syndromes are zero
  function automatic logic [6:0] model_enc(input logic [3:0] nib);
    for (int cw = 0; cw < 128; cw++) begin
      int data, s1, s2, s3;
      data = bitk(cw,5)*8 + bitk(cw,3)*4 + bitk(cw,2)*2 + bitk(cw,1);
      s1 = bitk(cw,7) ^ bitk(cw,5) ^ bitk(cw,3) ^ bitk(cw,1);
      s2 = bitk(cw,6) ^ bitk(cw,5) ^ bitk(cw,2) ^ bitk(cw,1);
      s3 = bitk(cw,4) ^ bitk(cw,3) ^ bitk(cw,2) ^ bitk(cw,1);
      if (data == int'(nib) && s1 == 0 && s2 == 0 && s3 == 0) return cw[6:0];
    end
    return 7'h00;
  endfunction

  typedef struct {
    logic [7:0] din;
    logic [6:0] lo_code;
    logic [6:0] hi_code;
  } vec_t;

  vec_t tbl[5];

  logic       mon_en = 1'b0;
  logic       last_in_fire = 1'b0;
  logic [6:0] exp_q[$];
  logic [6:0] exp_q2[$];
  int         mcount = 0;

  // Scoreboard for the random phase: compare at negedge, while handshake inputs are stable
  always @(negedge clk) begin
    if (mon_en) begin
      logic in_fire, out_fire;
      logic [6:0] e, e2;
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      check_output("rnd_cnt", cw_count, mcount & 32'hffff);
      check_output("rnd_cnt2", cw_count2, mcount % 4);
      if (out_fire) begin
        if (exp_q.size() == 0 || exp_q2.size() == 0) begin
          check_output("rnd_underflow", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          e2 = exp_q2.pop_front();
          check_output("rnd_code", out_code, e);
          check_output("rnd_code2", out_code2, e2);
          check_output("rnd_inj", out_injected, 0);
        end
        mcount++;
      end
      if (in_fire) begin
        exp_q.push_back(model_enc(in_data[3:0]));
        exp_q.push_back(model_enc(in_data[7:4]));
        exp_q2.push_back(model_enc(in_data[7:4]));
        exp_q2.push_back(model_enc(in_data[3:0]));
      end
      last_in_fire = in_fire;
    end
  end

  initial begin
    int xfers;
    tbl[0] = '{8'hA5, 7'h25, 7'h5A};
    tbl[1] = '{8'h00, 7'h00, 7'h00};
    tbl[2] = '{8'hFF, 7'h7F, 7'h7F};
    tbl[3] = '{8'h3C, 7'h3C, 7'h43};
    tbl[4] = '{8'h12, 7'h2A, 7'h69};

    rst_n = 1'b1;
    inj_valid = 1'b0;
    inj_pos = 3'd0;
    apply_stimulus(1'b0, 8'h00, 1'b1);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("rst_valid", out_valid, 0);
    check_output("rst_code", out_code, 0);
    check_output("rst_inj", out_injected, 0);
    check_output("rst_armed", inj_armed, 0);
    check_output("rst_cnt", cw_count, 0);
    check_output("rst_ready", in_ready, 1);

    // Back-to-back table bytes with out_ready held high
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(1'b1, tbl[i].din, 1'b1);
      check_output("tbl_in_ready", in_ready, 1);
      @(posedge clk);
      if (i > 0) xfers++;
      #1 in_valid = 1'b0;
      @(negedge clk);
      check_output("tbl_valid_a", out_valid, 1);
      check_output("tbl_code_a", out_code, tbl[i].lo_code);
      check_output("tbl_code2_a", out_code2, tbl[i].hi_code);
      check_output("tbl_busy", in_ready, 0);
      check_output("tbl_cnt", cw_count, xfers);
      check_output("tbl_cnt2", cw_count2, xfers % 4);
      @(posedge clk);
      xfers++;
      @(negedge clk);
      check_output("tbl_valid_b", out_valid, 1);
      check_output("tbl_code_b", out_code, tbl[i].hi_code);
      check_output("tbl_code2_b", out_code2, tbl[i].lo_code);
      check_output("tbl_ready_b", in_ready, 1);
    end
    @(posedge clk);
    xfers++;
    @(negedge clk);
    check_output("tbl_idle", out_valid, 0);
    check_output("tbl_cnt_end", cw_count, xfers);
    check_output("tbl_cnt2_end", cw_count2, xfers % 4);

    // Stall in FIRST and SECOND with a second byte waiting
    apply_stimulus(1'b1, 8'hA5, 1'b0);
    @(posedge clk);
    #1 in_data = 8'h12;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("stall_code_a", out_code, 7'h25);
      check_output("stall_ready_a", in_ready, 0);
      check_output("stall_valid", out_valid, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_output("stall_code_b", out_code, 7'h5A);
      check_output("stall_ready_b", in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_output("stall_next_a", out_code, 7'h2A);
    @(posedge clk);
    @(negedge clk);
    check_output("stall_next_b", out_code, 7'h69);
    @(posedge clk);
    @(negedge clk);
    check_output("stall_idle", out_valid, 0);

    // Injection at bit 3 on byte 0x05
    inj_valid = 1'b1;
    inj_pos = 3'd3;
    @(posedge clk);
    #1 inj_valid = 1'b0;
    @(negedge clk);
    check_output("inj_armed", inj_armed, 1);
    apply_stimulus(1'b1, 8'h05, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_output("inj_code", out_code, 7'h21);
    check_output("inj_code_model", out_code, model_enc(4'h5) ^ 7'h04);
    check_output("inj_flag", out_injected, 1);
    check_output("inj_cleared", inj_armed, 0);
    check_output("inj_code2", out_code2, model_enc(4'h0) ^ 7'h04);
    @(posedge clk);
    @(negedge clk);
    check_output("inj_clean_code", out_code, 7'h00);
    check_output("inj_clean_flag", out_injected, 0);
    @(posedge clk);

    // pos=0 keeps the arm; a request coinciding with a load targets the next load
    inj_valid = 1'b1;
    inj_pos = 3'd6;
    @(posedge clk);
    #1 inj_pos = 3'd0;
    @(posedge clk);
    #1 inj_valid = 1'b0;
    @(negedge clk);
    check_output("inj_pos0_keeps", inj_armed, 1);
    apply_stimulus(1'b1, 8'hA5, 1'b1);
    inj_valid = 1'b1;
    inj_pos = 3'd1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    inj_valid = 1'b0;
    @(negedge clk);
    check_output("inj6_code", out_code, model_enc(4'h5) ^ 7'h20);
    check_output("inj6_flag", out_injected, 1);
    check_output("inj_rearmed", inj_armed, 1);
    @(posedge clk);
    @(negedge clk);
    check_output("inj1_code", out_code, model_enc(4'hA) ^ 7'h01);
    check_output("inj1_flag", out_injected, 1);
    check_output("inj1_cleared", inj_armed, 0);
    @(posedge clk);
    @(negedge clk);

    // Asynchronous reset while stalled in SECOND
    apply_stimulus(1'b1, 8'h3C, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check_output("mid_code", out_code, 7'h43);
    #2 rst_n = 1'b0;
    #1;
    check_output("arst_valid", out_valid, 0);
    check_output("arst_code", out_code, 0);
    check_output("arst_cnt", cw_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("arst_ready", in_ready, 1);
    apply_stimulus(1'b1, 8'h3C, 1'b1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check_output("arst_code_a", out_code, model_enc(4'hC));
    check_output("arst_cnt_a", cw_count, 0);
    @(posedge clk);
    @(negedge clk);
    check_output("arst_code_b", out_code, model_enc(4'h3));
    check_output("arst_cnt_b", cw_count, 1);
    @(posedge clk);
    @(negedge clk);
    check_output("arst_cnt_end", cw_count, 2);

    // Randomized traffic against the queue model
    rst_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mcount = 0;
    last_in_fire = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!in_valid || last_in_fire) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 8'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk);
    #1 apply_stimulus(1'b0, 8'h00, 1'b1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    #1 mon_en = 1'b0;
    check_output("drain", exp_q.size(), 0);
    check_output("drain2", exp_q2.size(), 0);
    check_output("drain_idle", out_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
